// File: rtl/count_seq_checker.sv
// count_seq_checker: locks on to a +1 mod 2^WIDTH count stream and flags breaks/wraps; optional `RESET_TOLERANT_EN
module count_seq_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int LOCK_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 cnt_vld,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [7:0]           wrap_cnt,
  output logic [WIDTH-1:0]     last_val
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t               r_state, w_state;
  logic [3:0]           r_match, w_match;
  logic                 r_err_p, r_wrap_p, w_err_ev, w_wrap_ev, w_hit, w_max, w_urst;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt;
  logic [7:0]           r_wrap_cnt, w_wrap_cnt;
  logic [WIDTH-1:0]     r_last, w_last;
  // next-state, event detection and counter updates
  always_comb begin
    w_hit     = cnt_in == r_last + WIDTH'(1);
    w_max     = &r_last;
`ifdef RESET_TOLERANT_EN
    w_urst    = cnt_in == '0 && !w_max;
`else
    w_urst    = 1'b0;
`endif
    w_state   = r_state;
    w_match   = r_match;
    w_last    = r_last;
    w_err_ev  = 1'b0;
    w_wrap_ev = 1'b0;
    if (cnt_vld) begin
      w_last = cnt_in;
      case (r_state)
        HUNT: begin
          w_state = SYNC;
          w_match = '0;
        end
        SYNC: begin
          w_match = w_hit ? r_match + 4'd1 : '0;
          w_state = (w_hit && w_match == 4'(LOCK_THRESH)) ? LOCKED : SYNC;
        end
        LOCKED: begin
          w_wrap_ev = w_hit && w_max;
          w_err_ev  = !w_hit && !w_urst;
          w_state   = w_err_ev ? SYNC : LOCKED;
          w_match   = '0;
        end
        default: w_state = HUNT;
      endcase
    end
    w_err_cnt  = clr ? '0 : (w_err_ev && !(&r_err_cnt)) ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;
    w_wrap_cnt = clr ? '0 : r_wrap_cnt + {7'd0, w_wrap_ev};
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= HUNT;
      r_match    <= '0;
      r_err_p    <= 1'b0;
      r_wrap_p   <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
      r_last     <= '0;
    end else begin
      r_state    <= w_state;
      r_match    <= w_match;
      r_err_p    <= w_err_ev;
      r_wrap_p   <= w_wrap_ev;
      r_err_cnt  <= w_err_cnt;
      r_wrap_cnt <= w_wrap_cnt;
      r_last     <= w_last;
    end
  end
  assign locked     = r_state == LOCKED;
  assign err_pulse  = r_err_p;
  assign wrap_pulse = r_wrap_p;
  assign err_cnt    = r_err_cnt;
  assign wrap_cnt   = r_wrap_cnt;
  assign last_val   = r_last;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: random + directed stimulus against a behavioural model
module tb_count_seq_checker;
  localparam int LT = 3;
  logic       clk = 0, reset = 0, cnt_vld = 0, clr = 0;
  logic [3:0] cnt_in = 0;
  logic       locked, err_pulse, wrap_pulse, locked2, errp2, wrapp2;
  logic [7:0] err_cnt, wrap_cnt, wrap_cnt2;
  logic [1:0] err_cnt2;
  logic [3:0] last_val, last_val2;
  int n_chk = 0, n_fail = 0;
  bit m_hunt, m_lock, m_errp, m_wrapp;
  int m_run, m_last, m_err, m_wrap;
  always #5 clk = ~clk;
  count_seq_checker #(.WIDTH(4), .ERR_CNT_W(8), .LOCK_THRESH(LT)) u_dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .last_val(last_val));
  count_seq_checker #(.WIDTH(4), .ERR_CNT_W(2), .LOCK_THRESH(LT)) u_dut2 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .locked(locked2), .err_pulse(errp2), .wrap_pulse(wrapp2),
    .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2), .last_val(last_val2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_hunt = 1; m_lock = 0; m_errp = 0; m_wrapp = 0;
    m_run = 0; m_last = 0; m_err = 0; m_wrap = 0;
  endtask
  task automatic model_step(input bit v, input int x, input bit c);
    bit err_ev = 0, wrap_ev = 0, up_rst;
    int exp_v = (m_last + 1) % 16;
`ifdef RESET_TOLERANT_EN
    up_rst = x == 0 && m_last != 15;
`else
    up_rst = 0;
`endif
    if (v) begin
      if (m_hunt) begin
        m_hunt = 0; m_run = 0;
      end else if (!m_lock) begin
        m_run = x == exp_v ? m_run + 1 : 0;
        if (m_run >= LT) m_lock = 1;
      end else if (x == exp_v) wrap_ev = m_last == 15;
      else if (!up_rst) begin
        err_ev = 1; m_lock = 0; m_run = 0;
      end
      m_last = x;
    end
    m_errp = err_ev;
    m_wrapp = wrap_ev;
    m_err = c ? 0 : m_err + int'(err_ev);
    m_wrap = c ? 0 : (m_wrap + int'(wrap_ev)) % 256;
  endtask
  task automatic compare_all();
    check("locked", locked, m_lock);
    check("locked_w2", locked2, m_lock);
    check("err_pulse", err_pulse, m_errp);
    check("err_pulse_w2", errp2, m_errp);
    check("wrap_pulse", wrap_pulse, m_wrapp);
    check("err_cnt", err_cnt, m_err > 255 ? 255 : m_err);
    check("err_cnt_w2", err_cnt2, m_err > 3 ? 3 : m_err);
    check("wrap_cnt", wrap_cnt, m_wrap);
    check("last_val", last_val, m_last);
  endtask
  task automatic put(input bit v, input int x, input bit c);
    cnt_vld = v; cnt_in = 4'(x); clr = c;
    @(posedge clk);
    model_step(v, x, c);
    #1 compare_all();
  endtask
  task automatic inc(input int n);
    for (int i = 0; i < n; i++) put(1, (m_last + 1) % 16, 0);
  endtask
  task automatic async_reset();
    #2 reset = 0;
    #1 model_reset();
    check("arst_locked", locked, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_wrap_cnt", wrap_cnt, 0);
    check("arst_last_val", last_val, 0);
    check("arst_pulses", {err_pulse, wrap_pulse}, 0);
    #3 reset = 1;
  endtask
  initial begin
    model_reset();
    #12 reset = 1;
    for (int i = 0; i < 5; i++) put(0, 0, 0);
    check("t1_locked", locked, 0);
    check("t1_last", last_val, 0);
    put(1, 0, 0); put(1, 1, 0); put(1, 2, 0);
    check("t2_not_yet", locked, 0);
    put(1, 3, 0);
    check("t2_locked", locked, 1);
    inc(14);
    check("t3_wrap_cnt", wrap_cnt, 1);
    check("t3_err_cnt", err_cnt, 0);
    inc(4);
    put(1, 7, 0);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_unlocked", locked, 0);
    inc(3);
    check("t4_relock", locked, 1);
    put(1, 0, 0);
`ifdef RESET_TOLERANT_EN
    check("t5_err_cnt", err_cnt, 1);
    check("t5_locked", locked, 1);
`else
    check("t5_err_cnt", err_cnt, 2);
    check("t5_locked", locked, 0);
`endif
    inc(3);
    for (int i = 0; i < 5; i++) begin
      put(1, (m_last + 2) % 16, 0);
      inc(3);
    end
    check("t6_sat", err_cnt2, 3);
    put(1, (m_last + 2) % 16, 0);
    check("t6_sat_pulse", errp2, 1);
    check("t6_sat_hold", err_cnt2, 3);
    inc(3);
    put(1, (m_last + 1) % 16, 1);
    check("t6_clr_err", err_cnt, 0);
    check("t6_clr_wrap", wrap_cnt, 0);
    check("t6_clr_locked", locked, 1);
    async_reset();
    inc(LT);
    check("relock_early", locked, 0);
    inc(1);
    check("relock", locked, 1);
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(0, 19);
      int x = sel < 15 ? (m_last + 1) % 16 : sel == 15 ? m_last : sel == 16 ? 0 : $urandom_range(0, 15);
      put($urandom_range(0, 99) < 85, x, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 699) == 0) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
